mdu_param: RTL and testbench
============================

Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the E stage of the five-stage MIPS pipeline; successor to the fixed 32-bit, fixed-latency MDU.
- Width, multiply latency and divide latency are parameters.
- Adds multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU), a defined divide-by-zero/overflow result, and a `cancel` input driven by the CP0 exception request, so an in-flight op aborts without committing HI/LO.
- The stall controller uses `busy || start` to hold dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MUL_LAT, 5, busy cycles for MULT/MULTU/MADD*/MSUB*; must be >= 1.
- DIV_LAT, 10, busy cycles for DIV/DIVU; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  op valid in E this cycle.
- op  in  4  MDU op code (package enum).
- rs  in  WIDTH  operand A, forwarded.
- rt  in  WIDTH  operand B, forwarded.
- cancel  in  1  exception request; aborts and blocks commits.
- busy  out  1  long op in flight.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- md_out  out  WIDTH  combinational: hi if op==MFHI, lo if op==MFLO, else 0.

Behaviour:
- **Reset:** busy=0, hi=0, lo=0, state=IDLE, counter=0. Asserting reset mid-operation discards the op immediately, asynchronously.
- **FSM states:** IDLE, RUN.
- **Accept rule (IDLE):** a start is accepted on the edge where start=1, cancel=0, state=IDLE.
  - MTHI/MTLO: hi<=rs or lo<=rs on that edge; stay IDLE; busy stays 0.
  - MFHI/MFLO/NOP: no state change.
  - Long ops: latch the op kind, compute the full result into a pending register (hi_n, lo_n), load counter=L-1, go RUN.
- **Busy timing:** busy=1 for exactly L cycles after the accept edge (L=MUL_LAT or DIV_LAT).
  - On the edge where counter==0 in RUN, commit hi<=hi_n and lo<=lo_n, go IDLE, busy falls.
  - A start at edge k gives new HI/LO visible from cycle k+L.
  - With L=1, busy is high for one cycle.
- **Multiply arithmetic:**
  - MULT: signed 2W product, {hi,lo}.
  - MULTU: unsigned 2W product, {hi,lo}.
  - MADD/MADDU: {hi,lo} + product. MSUB/MSUBU: {hi,lo} - product. Both are mod 2^(2W) and use the HI/LO value at the accept edge.
- **Divide arithmetic:**
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divisor 0: lo = all ones, hi = rs.
  - DIV of MIN_INT by -1: lo = MIN_INT, hi = 0.
- **Start while RUN:** ignored; the stall controller guarantees it cannot happen. The assertion bench flags it.
- **Cancel:**
  - cancel=1 in RUN: go IDLE on the next edge, busy=0, no commit. This holds even when counter==0 that cycle, because cancel has priority over commit.
  - cancel=1 together with start in IDLE: start ignored, including MTHI/MTLO.
- **Reads:** md_out is combinational from current hi/lo. During RUN it returns pre-op values; stalling the reader is the stall controller's job.

Decomposition:
- Shared package `mdu_pkg`:
  - op enum: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - state enum: IDLE, RUN.
  - helper `is_long_op`.
- One natural sub-module: `mdu_div_core`, a combinational signed/unsigned divide that includes the zero/overflow rules. It is kept separate so it can later be swapped for an iterative core without touching the FSM.

Test Plan:
- Reset low mid-RUN (MULT accepted, 2 cycles in) → busy=0, hi=lo=0 immediately; stays IDLE after release.
- MULT rs=0xFFFFFFFF, rt=2, default params → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=1, lo=0xFFFFFFFE.
- DIV rs=-7, rt=2 → busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=7, rt=0 → lo=0xFFFFFFFF, hi=7. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- MTHI rs=5, then MTLO rs=3, then MADD rs=2, rt=3 → after 5 cycles hi=5, lo=9. Then MSUBU rs=rt=1 → lo=8, hi=5.
- MULT accepted, cancel pulsed on busy cycle 5 (commit cycle) → busy=0 next cycle; hi/lo keep prior values. MTLO with cancel=1 → lo unchanged.
- Param sweep WIDTH=16, MUL_LAT=1, DIV_LAT=3 → MULTU 0xFFFF×0xFFFF gives hi=0xFFFE, lo=0x0001 after 1 busy cycle. DIV busy exactly 3 cycles. Randomised ops checked against a reference model.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8,
    MADD  = 4'd9,
    MADDU = 4'd10,
    MSUB  = 4'd11,
    MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MUL_LAT or DIV_LAT cycles.
  function automatic logic is_long_op(input mdu_op_e op);
    return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  // Ops whose latency is DIV_LAT.
  function automatic logic is_div_op(input mdu_op_e op);
    return op inside {DIV, DIVU};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider with defined divide-by-zero and overflow results.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quo_c,
  output logic [WIDTH-1:0] rem_c
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  // Divide magnitudes, then restore signs; quotient truncates toward zero.
  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
    uq    = '0;
    ur    = '0;
    quo_c = '0;
    rem_c = '0;
    if (divisor == '0) begin
      quo_c = '1;
      rem_c = dividend;
    end else if (is_signed && (dividend == MIN_INT) && (divisor == '1)) begin
      quo_c = MIN_INT;
      rem_c = '0;
    end else begin
      uq    = a_mag / b_mag;
      ur    = a_mag % b_mag;
      quo_c = (a_neg ^ b_neg) ? -uq : uq;
      rem_c = a_neg ? -ur : ur;
    end
  end

endmodule

// File: rtl/mdu_param.sv
// Parametrised multiply/divide unit with MAC ops, cancel and fixed per-class latency.
module mdu_param
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] md_out
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned PROD_W  = 2 * WIDTH;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  hi_n_q, hi_n_d;
  logic [WIDTH-1:0]  lo_n_q, lo_n_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              mul_signed;
  logic              div_op;
  logic [PROD_W-1:0] rs_ext;
  logic [PROD_W-1:0] rt_ext;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mul_res;
  logic [PROD_W-1:0] long_res;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .dividend  (rs),
    .divisor   (rt),
    .is_signed (op == DIV),
    .quo_c     (quo),
    .rem_c     (rem)
  );

  // Full-width product (sign- or zero-extended operands) and accumulate against current HI/LO.
  always_comb begin
    accept     = start & ~cancel & (state_q == IDLE);
    mul_signed = (op == MULT) || (op == MADD) || (op == MSUB);
    div_op     = is_div_op(op);
    rs_ext     = {{WIDTH{mul_signed & rs[WIDTH-1]}}, rs};
    rt_ext     = {{WIDTH{mul_signed & rt[WIDTH-1]}}, rt};
    prod       = rs_ext * rt_ext;
    acc        = {hi_q, lo_q};
    case (op)
      MADD, MADDU: mul_res = acc + prod;
      MSUB, MSUBU: mul_res = acc - prod;
      default:     mul_res = prod;
    endcase
    long_res = div_op ? {rem, quo} : mul_res;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: cancel takes priority over the final-count commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_long_op(op)) state_d = RUN;
      RUN:  if (cancel || (cnt_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: MT writes, pending result capture, countdown and commit.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_n_d = hi_n_q;
    lo_n_d = lo_n_q;
    busy_d = (state_d == RUN);
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == MTHI) begin
            hi_d = rs;
          end else if (op == MTLO) begin
            lo_d = rs;
          end else if (is_long_op(op)) begin
            {hi_n_d, lo_n_d} = long_res;
            cnt_d = div_op ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
          end
        end
      end
      RUN: begin
        if (cancel) begin
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          hi_d = hi_n_q;
          lo_d = lo_n_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Move-from read path, combinational on current HI/LO.
  always_comb begin
    md_out = '0;
    if (op == MFHI)      md_out = hi_q;
    else if (op == MFLO) md_out = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// Scoreboard bench: default-width unit (index 0) and a 16-bit, MUL_LAT=1, DIV_LAT=3 unit (index 1).
module tb_mdu_param;
  import mdu_pkg::*;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start_v  [2];
  mdu_op_e     op_v     [2];
  logic [63:0] rs_v     [2];
  logic [63:0] rt_v     [2];
  logic        cancel_v [2];

  logic        busy_a, busy_b;
  logic [31:0] hi_a, lo_a, md_a;
  logic [15:0] hi_b, lo_b, md_b;

  logic        busy_v [2];
  logic [63:0] hi_v   [2];
  logic [63:0] lo_v   [2];
  logic [63:0] md_v   [2];

  assign busy_v[0] = busy_a;
  assign busy_v[1] = busy_b;
  assign hi_v[0]   = 64'(hi_a);
  assign hi_v[1]   = 64'(hi_b);
  assign lo_v[0]   = 64'(lo_a);
  assign lo_v[1]   = 64'(lo_b);
  assign md_v[0]   = 64'(md_a);
  assign md_v[1]   = 64'(md_b);

  mdu_param u_a (
    .clk    (clk),
    .reset  (reset),
    .start  (start_v[0]),
    .op     (op_v[0]),
    .rs     (rs_v[0][31:0]),
    .rt     (rt_v[0][31:0]),
    .cancel (cancel_v[0]),
    .busy   (busy_a),
    .hi     (hi_a),
    .lo     (lo_a),
    .md_out (md_a)
  );

  mdu_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) u_b (
    .clk    (clk),
    .reset  (reset),
    .start  (start_v[1]),
    .op     (op_v[1]),
    .rs     (rs_v[1][15:0]),
    .rt     (rt_v[1][15:0]),
    .cancel (cancel_v[1]),
    .busy   (busy_b),
    .hi     (hi_b),
    .lo     (lo_b),
    .md_out (md_b)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] mdl_hi [2];
  logic [63:0] mdl_lo [2];
  exp_t        exp0 [$];
  exp_t        exp1 [$];

  function automatic int width_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] mask_of(input int d);
    return (64'd1 << width_of(d)) - 64'd1;
  endfunction

  // Busy cycles an op should take on unit d; zero for single-cycle ops.
  function automatic int lat_of(input int d, input mdu_op_e o);
    case (o)
      MULT, MULTU, MADD, MADDU, MSUB, MSUBU: return (d == 0) ? 5 : 1;
      DIV, DIVU:                             return (d == 0) ? 10 : 3;
      default:                               return 0;
    endcase
  endfunction

  function automatic longint sx(input logic [63:0] x, input int w);
    return x[w-1] ? (longint'(x) - (longint'(1) << w)) : longint'(x);
  endfunction

  // Reference arithmetic using plain integer math on w-bit values.
  function automatic void ref_long(input int w, input mdu_op_e o,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [63:0] hi_in, input logic [63:0] lo_in,
                                   output logic [63:0] hi_out, output logic [63:0] lo_out);
    logic [63:0]  m;
    logic [127:0] acc, p, r;
    longint       sa, sb, sp;
    m   = (64'd1 << w) - 64'd1;
    acc = (128'(hi_in) << w) | 128'(lo_in);
    sa  = sx(a, w);
    sb  = sx(b, w);
    sp  = sa * sb;
    p   = 128'(a) * 128'(b);
    if (o inside {MULT, MADD, MSUB}) p = {{64{sp[63]}}, sp};
    r = p;
    if (o inside {MADD, MADDU}) r = acc + p;
    if (o inside {MSUB, MSUBU}) r = acc - p;
    hi_out = 64'(r >> w) & m;
    lo_out = 64'(r) & m;
    if (o == DIV || o == DIVU) begin
      if (b == 64'd0) begin
        lo_out = m;
        hi_out = a;
      end else if (o == DIV) begin
        lo_out = 64'(sa / sb) & m;
        hi_out = 64'(sa % sb) & m;
      end else begin
        lo_out = (a / b) & m;
        hi_out = (a % b) & m;
      end
    end
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  // Compare a finished long op (busy just fell) against the oldest expectation.
  task automatic pop_check(input int d, input int len);
    exp_t e;
    int   sz;
    sz = (d == 0) ? exp0.size() : exp1.size();
    if (sz == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_unexpected dut%0d: got busy for %0d cycles expected no busy", d, len);
      return;
    end
    if (d == 0) e = exp0.pop_front();
    else        e = exp1.pop_front();
    check("busy_len", d, 64'(len), 64'(e.len));
    check("sb_hi", d, hi_v[d], e.hi);
    check("sb_lo", d, lo_v[d], e.lo);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    int len = 0;
    always @(negedge clk) begin
      if (busy_v[g] === 1'b1) len++;
      else if (len > 0) begin
        pop_check(g, len);
        len = 0;
      end
    end
  end

  task automatic wait_idle(input int d);
    for (int i = 0; i < 300; i++) begin
      if (busy_v[d] === 1'b0) return;
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL idle_timeout dut%0d: got busy after 300 cycles expected idle", d);
  endtask

  // Issue one op; cancel_cyc>0 pulses cancel in that busy cycle, cancel_idle raises cancel with start.
  task automatic issue(input int d, input mdu_op_e o, input logic [63:0] a_in, input logic [63:0] b_in,
                       input int cancel_cyc, input bit cancel_idle);
    int          L;
    logic [63:0] a, b, nh, nl;
    exp_t        e;
    L = lat_of(d, o);
    a = a_in & mask_of(d);
    b = b_in & mask_of(d);
    @(negedge clk);
    start_v[d]  = 1'b1;
    op_v[d]     = o;
    rs_v[d]     = a;
    rt_v[d]     = b;
    cancel_v[d] = cancel_idle;
    if (!cancel_idle) begin
      if (L > 0) begin
        ref_long(width_of(d), o, a, b, mdl_hi[d], mdl_lo[d], nh, nl);
        if (cancel_cyc > 0) begin
          e.hi = mdl_hi[d]; e.lo = mdl_lo[d]; e.len = cancel_cyc;
        end else begin
          e.hi = nh; e.lo = nl; e.len = L;
          mdl_hi[d] = nh;
          mdl_lo[d] = nl;
        end
        push(d, e);
      end else if (o == MTHI) begin
        mdl_hi[d] = a;
      end else if (o == MTLO) begin
        mdl_lo[d] = a;
      end
    end
    @(posedge clk);
    #1;
    start_v[d]  = 1'b0;
    cancel_v[d] = 1'b0;
    op_v[d]     = NOP;
    if (L > 0 && !cancel_idle) begin
      if (cancel_cyc > 0) begin
        repeat (cancel_cyc - 1) begin
          @(posedge clk);
          #1;
        end
        cancel_v[d] = 1'b1;
        @(posedge clk);
        #1;
        cancel_v[d] = 1'b0;
      end
      wait_idle(d);
    end
  endtask

  task automatic read_check(input int d);
    @(negedge clk);
    op_v[d] = MFHI;
    #1 check("mfhi", d, md_v[d], mdl_hi[d]);
    op_v[d] = MFLO;
    #1 check("mflo", d, md_v[d], mdl_lo[d]);
    op_v[d] = NOP;
    #1 check("md_nop", d, md_v[d], 64'd0);
  endtask

  task automatic expect_hl(input int d, input string name, input logic [63:0] h, input logic [63:0] l);
    check({name, "_hi"}, d, hi_v[d], h);
    check({name, "_lo"}, d, lo_v[d], l);
  endtask

  function automatic logic [63:0] rnd_opnd(input int d);
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return '1;
      3:       return 64'd1 << (width_of(d) - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    exp_t    e;
    mdu_op_e o;
    int      L, cc;
    bit      ci;

    for (int d = 0; d < 2; d++) begin
      start_v[d]  = 1'b0;
      op_v[d]     = NOP;
      rs_v[d]     = '0;
      rt_v[d]     = '0;
      cancel_v[d] = 1'b0;
      mdl_hi[d]   = '0;
      mdl_lo[d]   = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", d, 64'(busy_v[d]), 64'd0);
      expect_hl(d, "rst", 64'd0, 64'd0);
    end

    // Reset asserted two cycles into a MULTU discards it immediately.
    @(negedge clk);
    start_v[0] = 1'b1;
    op_v[0]    = MULTU;
    rs_v[0]    = 64'hFFFF_FFFF;
    rt_v[0]    = 64'hFFFF_FFFF;
    e.hi = 64'd0; e.lo = 64'd0; e.len = 2;
    push(0, e);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    op_v[0]    = NOP;
    @(posedge clk);
    #1 check("run_busy", 0, 64'(busy_v[0]), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", 0, 64'(busy_v[0]), 64'd0);
    expect_hl(0, "midrst", 64'd0, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_after_rst", 0, 64'(busy_v[0]), 64'd0);

    // Directed arithmetic on the default-width unit.
    issue(0, MULT,  64'hFFFF_FFFF, 64'd2, 0, 0);
    expect_hl(0, "mult", 64'hFFFF_FFFF, 64'hFFFF_FFFE);
    issue(0, MULTU, 64'hFFFF_FFFF, 64'd2, 0, 0);
    expect_hl(0, "multu", 64'd1, 64'hFFFF_FFFE);
    issue(0, DIV,   64'hFFFF_FFF9, 64'd2, 0, 0);
    expect_hl(0, "div_neg", 64'hFFFF_FFFF, 64'hFFFF_FFFD);
    issue(0, DIVU,  64'd7, 64'd0, 0, 0);
    expect_hl(0, "divu_zero", 64'd7, 64'hFFFF_FFFF);
    issue(0, DIV,   64'h8000_0000, 64'hFFFF_FFFF, 0, 0);
    expect_hl(0, "div_ovf", 64'd0, 64'h8000_0000);
    issue(0, MTHI,  64'd5, 64'd0, 0, 0);
    issue(0, MTLO,  64'd3, 64'd0, 0, 0);
    issue(0, MADD,  64'd2, 64'd3, 0, 0);
    expect_hl(0, "madd", 64'd5, 64'd9);
    issue(0, MSUBU, 64'd1, 64'd1, 0, 0);
    expect_hl(0, "msubu", 64'd5, 64'd8);
    issue(0, MULT,  64'd3, 64'd4, 5, 0);
    expect_hl(0, "cancel_commit", 64'd5, 64'd8);
    issue(0, MTLO,  64'h77, 64'd0, 0, 1);
    expect_hl(0, "mtlo_cancel", 64'd5, 64'd8);
    read_check(0);

    // Directed checks on the narrow, short-latency unit.
    issue(1, MULTU, 64'hFFFF, 64'hFFFF, 0, 0);
    expect_hl(1, "n_multu", 64'hFFFE, 64'h0001);
    issue(1, DIV,   64'd100, 64'd7, 0, 0);
    expect_hl(1, "n_div", 64'd2, 64'd14);
    issue(1, DIV,   64'h8000, 64'hFFFF, 0, 0);
    expect_hl(1, "n_div_ovf", 64'd0, 64'h8000);
    read_check(1);

    // Randomised ops with occasional cancels, against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        o  = mdu_op_e'(4'($urandom_range(0, 12)));
        L  = lat_of(d, o);
        cc = 0;
        ci = ($urandom_range(0, 11) == 0);
        if (L > 0 && $urandom_range(0, 7) == 0) cc = $urandom_range(1, L);
        issue(d, o, rnd_opnd(d), rnd_opnd(d), cc, ci);
        if (i % 4 == 0) read_check(d);
      end
      read_check(d);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 0, 64'(exp0.size() + exp1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
